// File: rtl/xaps_api_pkg.sv
// Shared types and constants for the XAPS API initiator and its command FIFO.
package xaps_api_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        BACKOFF,
        DONE
    } api_state_e;

    localparam logic [31:0] STATUS_BUSY    = 32'h0000_0002;
    localparam logic [31:0] STATUS_TIMEOUT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0]   endpoint;
        logic [7:0]    method;
        logic [1023:0] payload;
    } api_cmd_t;

endpackage

// File: rtl/xaps_cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit so full and
// empty are distinguishable, and the low bits index storage directly.
module xaps_cmd_fifo
    import xaps_api_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  api_cmd_t push_data,
    input  logic     pop,
    output api_cmd_t pop_data,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    api_cmd_t      mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

endmodule

// File: rtl/xaps_api_initiator.sv
// Host-side XAPS API initiator: queues commands and issues them one at a time,
// with response timeout, BUSY/timeout retry after a backoff, and a valid/ready result.
module xaps_api_initiator
    import xaps_api_pkg::*;
#(
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int BACKOFF_CYCLES = 16,
    parameter int TIMER_W        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [31:0]   cmd_endpoint,
    input  logic [7:0]    cmd_method,
    input  logic [1023:0] cmd_payload,
    output logic [31:0]   api_endpoint,
    output logic [7:0]    api_method,
    output logic [1023:0] api_payload,
    output logic          api_request,
    input  logic [31:0]   api_status,
    input  logic [1023:0] api_response,
    input  logic          api_response_valid,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_status,
    output logic [1023:0] rsp_data,
    output logic [3:0]    rsp_retries,
    output logic          rsp_timeout,
    output logic          busy,
    output logic [15:0]   stale_cnt
);
    api_state_e         state, state_nxt;
    api_cmd_t           push_cmd, head_cmd;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic [TIMER_W-1:0] timer;
    logic [3:0]         retries;
    logic               timer_expired, backoff_done, can_retry, retry_now;

    assign push_cmd.endpoint = cmd_endpoint;
    assign push_cmd.method   = cmd_method;
    assign push_cmd.payload  = cmd_payload;

    assign cmd_ready = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    xaps_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_valid && cmd_ready),
        .push_data (push_cmd),
        .pop       (fifo_pop),
        .pop_data  (head_cmd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign timer_expired = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign backoff_done  = (timer == TIMER_W'(BACKOFF_CYCLES - 1));
    assign can_retry     = (retries < 4'(MAX_RETRY));
    // A response landing on the expiry cycle is judged on its status, not as a timeout.
    assign retry_now     = api_response_valid ? ((api_status == STATUS_BUSY) && can_retry)
                                              : (timer_expired && can_retry);

    assign api_request = (state == ISSUE);
    assign rsp_valid   = (state == DONE);
    assign busy        = (state != IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fifo_pop) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT: begin
                if (retry_now)                                state_nxt = BACKOFF;
                else if (api_response_valid || timer_expired) state_nxt = DONE;
            end
            BACKOFF: if (backoff_done) state_nxt = ISSUE;
            DONE:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer        <= '0;
            retries      <= '0;
            api_endpoint <= '0;
            api_method   <= '0;
            api_payload  <= '0;
            rsp_status   <= '0;
            rsp_data     <= '0;
            rsp_retries  <= '0;
            rsp_timeout  <= 1'b0;
            stale_cnt    <= '0;
        end else begin
            // One counter serves both WAIT timeout and BACKOFF; it restarts on every state change.
            if (state_nxt != state)                    timer <= '0;
            else if (state == WAIT || state == BACKOFF) timer <= timer + TIMER_W'(1);

            if (fifo_pop) begin
                api_endpoint <= head_cmd.endpoint;
                api_method   <= head_cmd.method;
                api_payload  <= head_cmd.payload;
                retries      <= '0;
            end

            if (state == WAIT && state_nxt == BACKOFF) retries <= retries + 4'd1;

            if (state == WAIT && state_nxt == DONE) begin
                rsp_retries <= retries;
                rsp_timeout <= !api_response_valid;
                rsp_status  <= api_response_valid ? api_status : STATUS_TIMEOUT;
                rsp_data    <= api_response_valid ? api_response : '0;
            end

            if (api_response_valid && state != WAIT && stale_cnt != 16'hFFFF) begin
                stale_cnt <= stale_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_xaps_api_initiator.sv
// Directed bench for xaps_api_initiator: scripted XAPS responder, per-command
// outcome model, cycle-by-cycle output checker and literal expectations.
module tb_xaps_api_initiator;
    localparam int CMD_DEPTH      = 4;
    localparam int TIMEOUT_CYCLES = 8;
    localparam int MAX_RETRY      = 3;
    localparam int BACKOFF_CYCLES = 16;
    localparam int TIMER_W        = 16;
    localparam logic [31:0] ST_BUSY    = 32'h0000_0002;
    localparam logic [31:0] ST_TIMEOUT = 32'hFFFF_FFFF;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready;
    logic [31:0]   cmd_endpoint;
    logic [7:0]    cmd_method;
    logic [1023:0] cmd_payload;
    logic [31:0]   api_endpoint;
    logic [7:0]    api_method;
    logic [1023:0] api_payload;
    logic          api_request;
    logic [31:0]   api_status;
    logic [1023:0] api_response;
    logic          api_response_valid;
    logic          rsp_valid, rsp_ready;
    logic [31:0]   rsp_status;
    logic [1023:0] rsp_data;
    logic [3:0]    rsp_retries;
    logic          rsp_timeout, busy;
    logic [15:0]   stale_cnt;

    xaps_api_initiator #(
        .CMD_DEPTH(CMD_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .MAX_RETRY(MAX_RETRY),
        .BACKOFF_CYCLES(BACKOFF_CYCLES), .TIMER_W(TIMER_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_endpoint(cmd_endpoint), .cmd_method(cmd_method), .cmd_payload(cmd_payload),
        .api_endpoint(api_endpoint), .api_method(api_method), .api_payload(api_payload),
        .api_request(api_request), .api_status(api_status), .api_response(api_response),
        .api_response_valid(api_response_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
        .rsp_data(rsp_data), .rsp_retries(rsp_retries), .rsp_timeout(rsp_timeout),
        .busy(busy), .stale_cnt(stale_cnt)
    );

    typedef struct {
        int            dly;    // cycles after the request; <1 means never answered
        logic [31:0]   st;
        logic [1023:0] data;
    } reply_t;

    typedef struct {
        logic [31:0]   ep;
        logic [7:0]    me;
        logic [1023:0] pl;
        logic [31:0]   st;
        logic [1023:0] data;
        int            retries;
        logic          tmo;
    } exp_t;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    reply_t rq[64];
    int     rq_tail = 0, rq_head = 0;
    exp_t   eq[64];
    int     eq_tail = 0, eq_head = 0;
    reply_t scr[$];
    int     req_log[256];
    int     req_n = 0;
    int     rsp_n = 0;
    int     stale_req = 0;

    function automatic void check(input string name, input logic [1023:0] act, input logic [1023:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act[255:0], req[255:0]);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic add_reply(input int d, input logic [31:0] st, input logic [1023:0] data);
        reply_t r;
        r.dly = d; r.st = st; r.data = data;
        scr.push_back(r);
    endtask

    // Outcome model: walk the scripted attempts using the retry rules.
    task automatic plan(input logic [31:0] ep, input logic [7:0] me, input logic [1023:0] pl);
        exp_t   e;
        reply_t r;
        int     tries;
        tries = 0;
        e.ep = ep; e.me = me; e.pl = pl;
        e.st = '0; e.data = '0; e.tmo = 1'b0;
        forever begin
            if (scr.size() > 0) r = scr.pop_front();
            else begin r.dly = -1; r.st = '0; r.data = '0; end
            rq[rq_tail % 64] = r;
            rq_tail++;
            if (r.dly < 1 || r.dly > TIMEOUT_CYCLES) begin
                if (tries < MAX_RETRY) tries++;
                else begin e.st = ST_TIMEOUT; e.data = '0; e.tmo = 1'b1; break; end
            end else if (r.st == ST_BUSY && tries < MAX_RETRY) begin
                tries++;
            end else begin
                e.st = r.st; e.data = r.data; e.tmo = 1'b0; break;
            end
        end
        e.retries = tries;
        eq[eq_tail % 64] = e;
        eq_tail++;
    endtask

    // XAPS responder: answers each request according to the next scripted reply.
    initial begin
        reply_t cur;
        int     fire_at;
        bit     pend;
        int     stale_done;
        pend = 1'b0; fire_at = 0; stale_done = 0;
        api_response_valid = 1'b0; api_status = '0; api_response = '0;
        forever begin
            @(posedge clk);
            #1;
            api_response_valid = 1'b0;
            if (!rst_n) begin
                pend = 1'b0;
                rq_head = rq_tail;
            end else begin
                if (api_request && rq_head != rq_tail) begin
                    cur = rq[rq_head % 64];
                    rq_head++;
                    if (cur.dly > 0) begin pend = 1'b1; fire_at = cyc + cur.dly; end
                end
                if (pend && cyc == fire_at) begin
                    api_response_valid = 1'b1; api_status = cur.st; api_response = cur.data;
                    pend = 1'b0;
                end
                if (stale_req != stale_done) begin
                    api_response_valid = 1'b1; api_status = '0; api_response = '0;
                    stale_done = stale_req;
                end
            end
        end
    end

    // Per-cycle compare of DUT outputs against the model queue.
    initial begin
        exp_t          e;
        logic          hold;
        logic [31:0]   h_st;
        logic [1023:0] h_d;
        logic [3:0]    h_rt;
        logic          h_to;
        hold = 1'b0; h_st = '0; h_d = '0; h_rt = '0; h_to = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                eq_head = eq_tail;
                hold = 1'b0;
                continue;
            end
            if (api_request) begin
                req_log[req_n % 256] = cyc;
                req_n++;
            end
            if (eq_head == eq_tail) begin
                check("idle_api_request", api_request, 1'b0);
                check("idle_rsp_valid", rsp_valid, 1'b0);
                hold = 1'b0;
            end else begin
                e = eq[eq_head % 64];
                if (api_request) begin
                    check("api_endpoint", api_endpoint, e.ep);
                    check("api_method", api_method, e.me);
                    check("api_payload", api_payload, e.pl);
                end
                if (rsp_valid) begin
                    if (hold) begin
                        check("hold_rsp_status", rsp_status, h_st);
                        check("hold_rsp_data", rsp_data, h_d);
                        check("hold_rsp_retries", rsp_retries, h_rt);
                        check("hold_rsp_timeout", rsp_timeout, h_to);
                    end
                    if (rsp_ready) begin
                        check("rsp_status", rsp_status, e.st);
                        check("rsp_data", rsp_data, e.data);
                        check("rsp_retries", rsp_retries, 4'(e.retries));
                        check("rsp_timeout", rsp_timeout, e.tmo);
                        eq_head++;
                        rsp_n++;
                    end
                    hold = !rsp_ready;
                    h_st = rsp_status; h_d = rsp_data; h_rt = rsp_retries; h_to = rsp_timeout;
                end else begin
                    hold = 1'b0;
                end
            end
        end
    end

    task automatic push(input logic [31:0] ep, input logic [7:0] me, input logic [1023:0] pl,
                        output int acc);
        int g;
        g = 0; acc = -1;
        cmd_valid = 1'b1; cmd_endpoint = ep; cmd_method = me; cmd_payload = pl;
        while (g < 500 && acc < 0) begin
            @(negedge clk);
            if (cmd_ready) acc = cyc;
            g++;
        end
        if (acc < 0) check("push_accept", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int at, output logic [31:0] st,
                            output logic [1023:0] d, output logic [3:0] rt, output logic tmo);
        int g;
        g = 0; at = -1; st = '0; d = '0; rt = '0; tmo = 1'b0;
        while (g < 500 && at < 0) begin
            @(negedge clk);
            if (rsp_valid) begin
                at = cyc; st = rsp_status; d = rsp_data; rt = rsp_retries; tmo = rsp_timeout;
            end
            g++;
        end
        if (at < 0) check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int            acc, at, r0, base, g;
        int            a[5];
        logic [31:0]   st;
        logic [1023:0] d;
        logic [3:0]    rt;
        logic          tmo;

        rst_n = 1'b0; rsp_ready = 1'b1;
        cmd_valid = 1'b0; cmd_endpoint = '0; cmd_method = '0; cmd_payload = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_cmd_ready", cmd_ready, 1'b1);
        check("reset_api_request", api_request, 1'b0);
        check("reset_rsp_valid", rsp_valid, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_stale_cnt", stale_cnt, 16'd0);
        check("reset_api_endpoint", api_endpoint, 32'd0);
        check("reset_rsp_status", rsp_status, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stale response while idle
        stale_req++;
        repeat (3) @(posedge clk);
        #1;
        check("stale_cnt_after_idle_strobe", stale_cnt, 16'd1);

        // Single command, reply 5 cycles after the request
        add_reply(5, 32'h0, 1024'h1234);
        plan(32'h10, 8'h01, 1024'hABCD);
        r0 = req_n;
        push(32'h10, 8'h01, 1024'hABCD, acc);
        wait_rsp("t1", at, st, d, rt, tmo);
        check_int("t1_req_count", req_n - r0, 1);
        check_int("t1_req_latency", req_log[r0 % 256] - acc, 2);
        check_int("t1_rsp_latency", at - acc, 8);
        check("t1_status", st, 32'h0);
        check("t1_data", d, 1024'h1234);
        check("t1_retries", rt, 4'd0);
        check("t1_timeout", tmo, 1'b0);

        // No responder: timeout exhausts all retries
        plan(32'h20, 8'h02, 1024'h5555);
        r0 = req_n;
        push(32'h20, 8'h02, 1024'h5555, acc);
        wait_rsp("t2", at, st, d, rt, tmo);
        check_int("t2_req_count", req_n - r0, 4);
        for (int k = 0; k < 3; k++) begin
            check_int("t2_req_spacing", req_log[(r0 + k + 1) % 256] - req_log[(r0 + k) % 256], 25);
        end
        check("t2_status", st, 32'hFFFF_FFFF);
        check("t2_data", d, 1024'h0);
        check("t2_retries", rt, 4'd3);
        check("t2_timeout", tmo, 1'b1);

        // BUSY then OK
        add_reply(3, 32'h2, 1024'hDEAD);
        add_reply(3, 32'h0, 1024'hBEEF);
        plan(32'h30, 8'h03, 1024'h77);
        r0 = req_n;
        push(32'h30, 8'h03, 1024'h77, acc);
        wait_rsp("t3", at, st, d, rt, tmo);
        check_int("t3_req_count", req_n - r0, 2);
        check_int("t3_req_spacing", req_log[(r0 + 1) % 256] - req_log[r0 % 256], 20);
        check("t3_status", st, 32'h0);
        check("t3_data", d, 1024'hBEEF);
        check("t3_retries", rt, 4'd1);

        // Response on the same cycle as timer expiry
        add_reply(TIMEOUT_CYCLES, 32'h55, 1024'h99);
        plan(32'h40, 8'h04, 1024'h4);
        r0 = req_n;
        push(32'h40, 8'h04, 1024'h4, acc);
        wait_rsp("t4", at, st, d, rt, tmo);
        check_int("t4_req_count", req_n - r0, 1);
        check("t4_status", st, 32'h55);
        check("t4_timeout", tmo, 1'b0);
        check("t4_retries", rt, 4'd0);

        // Backpressure: six commands, consumer stalled
        rsp_ready = 1'b0;
        base = rsp_n;
        for (int i = 0; i < 6; i++) begin
            add_reply(2, 32'h0, 1024'(i + 100));
            plan(32'h100 + 32'(i), 8'(i), 1024'(i + 1000));
        end
        for (int i = 0; i < 5; i++) push(32'h100 + 32'(i), 8'(i), 1024'(i + 1000), a[i]);
        check_int("t5_five_pushes_unstalled", a[4] - a[0], 4);
        cmd_valid = 1'b1; cmd_endpoint = 32'h105; cmd_method = 8'd5; cmd_payload = 1024'(1005);
        repeat (3) begin
            @(negedge clk);
            check("t5_cmd_ready_full", cmd_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        push(32'h105, 8'd5, 1024'(1005), acc);
        g = 0;
        while (g < 600 && rsp_n - base < 6) begin
            @(negedge clk);
            g++;
        end
        check_int("t5_rsp_count", rsp_n - base, 6);
        repeat (3) @(posedge clk);
        #1;
        check("t5_idle_after_drain", busy, 1'b0);

        // Reset during WAIT with two commands queued
        plan(32'h50, 8'h05, 1024'h50);
        add_reply(2, 32'h0, 1024'h51);
        plan(32'h51, 8'h06, 1024'h51);
        add_reply(2, 32'h0, 1024'h52);
        plan(32'h52, 8'h07, 1024'h52);
        push(32'h50, 8'h05, 1024'h50, acc);
        push(32'h51, 8'h06, 1024'h51, at);
        push(32'h52, 8'h07, 1024'h52, at);
        repeat (2) @(posedge clk);
        #1;
        check("t6_busy_before_reset", busy, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst_api_request", api_request, 1'b0);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_cmd_ready", cmd_ready, 1'b1);
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_api_endpoint", api_endpoint, 32'h0);
        check("t6_rst_api_payload", api_payload, 1024'h0);
        check("t6_rst_stale_cnt", stale_cnt, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        r0 = req_n;
        repeat (40) @(posedge clk);
        #1;
        check_int("t6_no_request_after_reset", req_n - r0, 0);

        // Fresh command after reset completes normally
        add_reply(4, 32'h0, 1024'h4242);
        plan(32'h60, 8'h08, 1024'h60);
        r0 = req_n;
        push(32'h60, 8'h08, 1024'h60, acc);
        wait_rsp("t7", at, st, d, rt, tmo);
        check_int("t7_req_latency", req_log[r0 % 256] - acc, 2);
        check("t7_data", d, 1024'h4242);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xaps_api_initiator.md
Name: xaps_api_initiator

Overview:
- Host-side initiator for the XAPS API port. It is the requester end of the api_endpoint/api_method/api_payload/api_request → api_status/api_response/api_response_valid handshake.
- Queues commands from a local controller and issues them one at a time. Enforces a response timeout, retries on timeout or BUSY status, and returns each result over a valid/ready response channel.
- Sits between the on-chip management controller and xaps_top at FPGA top level.

Parameters:
- CMD_DEPTH, 4: command FIFO entries; power of 2, ≥2.
- TIMEOUT_CYCLES, 1024: WAIT cycles before a timeout is declared; 2..2^TIMER_W-1.
- MAX_RETRY, 3: re-issues allowed per command; ≤15.
- BACKOFF_CYCLES, 16: idle cycles between a failed attempt and its re-issue; ≥1.
- TIMER_W, 16: width of the shared timeout/backoff counter.

Ports:
- clk  in  1  system clock; sole clock domain.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_endpoint  in  32  target endpoint.
- cmd_method  in  8  API method code.
- cmd_payload  in  1024  request payload.
- api_endpoint  out  32  to XAPS.
- api_method  out  8  to XAPS.
- api_payload  out  1024  to XAPS.
- api_request  out  1  one-cycle request strobe.
- api_status  in  32  from XAPS; sampled with api_response_valid.
- api_response  in  1024  from XAPS.
- api_response_valid  in  1  one-cycle response strobe.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_status  out  32  final status, or STATUS_TIMEOUT.
- rsp_data  out  1024  final response payload; 0 on timeout.
- rsp_retries  out  4  re-issues consumed.
- rsp_timeout  out  1  final attempt timed out.
- busy  out  1  state≠IDLE or FIFO non-empty.
- stale_cnt  out  16  responses dropped outside WAIT; saturating.

Behaviour:

Reset:
- All registered outputs are 0. FIFO is empty and FSM is in IDLE.
- cmd_ready = !full (combinational), so it reads 1 out of reset.
- Reset asserted mid-operation abandons the in-flight command. api_request drops immediately and the FIFO is flushed.

Command FIFO:
- Push on cmd_valid && cmd_ready.
- When full, cmd_ready stays 0 even in a cycle that pops. There is no write-through.

FSM states: IDLE, ISSUE, WAIT, BACKOFF, DONE.
- IDLE:
  - FIFO non-empty → pop head into the api_* output registers, clear retry count → ISSUE.
- ISSUE:
  - api_request=1 for exactly this cycle; timer cleared → WAIT.
  - api_endpoint/method/payload stay stable from ISSUE until the next pop.
- WAIT:
  - Timer increments each cycle.
  - On api_response_valid with api_status==STATUS_BUSY and retries<MAX_RETRY: retries++ → BACKOFF.
  - On api_response_valid otherwise: capture api_status/api_response into rsp_*, rsp_timeout=0 → DONE.
  - When the timer reaches TIMEOUT_CYCLES-1 with no response:
    - retries<MAX_RETRY → retries++ → BACKOFF.
    - else rsp_status=STATUS_TIMEOUT, rsp_data=0, rsp_timeout=1 → DONE.
  - A response in the same cycle as timer expiry wins over the timeout.
- BACKOFF:
  - Count BACKOFF_CYCLES cycles, then → ISSUE. The same latched command is re-driven.
- DONE:
  - rsp_valid=1 and all rsp_* held stable until rsp_ready.
  - On rsp_valid&&rsp_ready → IDLE; rsp_valid deasserts next cycle.
  - The FIFO may still accept pushes in this state.

Latency:
- Command accepted at edge 0 with FSM idle and FIFO empty → api_request high in cycle 2.
- Response strobe in WAIT cycle k → rsp_valid high in cycle k+1.

Stale responses:
- api_response_valid in any state other than WAIT is ignored and increments stale_cnt.
- stale_cnt saturates at 16'hFFFF.

rsp_retries:
- Equals the number of re-issues performed (0..MAX_RETRY).

Decomposition:
- Package xaps_api_pkg:
  - api_state_e enum (IDLE, ISSUE, WAIT, BACKOFF, DONE).
  - STATUS_BUSY = 32'h0000_0002.
  - STATUS_TIMEOUT = 32'hFFFF_FFFF.
  - api_cmd_t packed struct {endpoint[31:0], method[7:0], payload[1023:0]}.
- Sub-module xaps_cmd_fifo: parameterised synchronous FIFO of api_cmd_t with push/pop/full/empty, CMD_DEPTH entries, pointer wrap by power-of-2 masking.
- The FSM, timer and response registers stay in xaps_api_initiator.

Test Plan:
- Single command: endpoint 32'h10, method 8'h01, payload 1024'hABCD. XAPS model replies 5 cycles after the request with status 0 and response 1024'h1234 → api_request pulses once in cycle 2; rsp_valid with rsp_status=0, rsp_data=1234, rsp_retries=0, rsp_timeout=0.
- Timeout exhaustion, TIMEOUT_CYCLES=8, MAX_RETRY=3, no responder → exactly 4 api_request pulses spaced 8+16+1 cycles apart; rsp_status=FFFF_FFFF, rsp_data=0, rsp_retries=3, rsp_timeout=1.
- BUSY then OK: first reply status 2, second reply status 0 → two api_request pulses separated by BACKOFF; rsp_status=0, rsp_retries=1.
- Backpressure: push 6 commands with rsp_ready=0, CMD_DEPTH=4 → cmd_ready drops after 4 FIFO entries plus 1 in flight. Releasing rsp_ready drains all commands in push order with no loss or duplication.
- Edge races:
  - Response strobe in the same cycle as timer expiry → accepted as a normal response with rsp_timeout=0.
  - Response strobe while IDLE → stale_cnt 0→1, no rsp_valid.
- Reset mid-WAIT with 2 commands queued → all outputs 0 asynchronously, busy=0, cmd_ready=1. After release, no api_request occurs until a new command is pushed.
